// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU core: a 2-entry elastic buffer with derived zero/neg flags,
// add-with-carry feedback flag, sticky error status and a saturating retired-op counter.
module alu_wb_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_c_out,
    input  logic             in_overflow,
    input  logic             in_borrow,
    input  logic             in_invalid_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [5:0]       out_flags,
    output logic             carry_flag,
    output logic [2:0]       sticky_status,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd1,
        OP_ADC  = 4'd2,
        OP_SUB  = 4'd3
    } op_e;

    logic [WIDTH-1:0] r_y_mem   [2];
    logic [5:0]       r_flg_mem [2];
    logic [1:0]       r_count;
    logic             r_head;
    logic             r_tail;
    logic             r_carry;
    logic [2:0]       r_sticky;
    logic [CNT_W-1:0] r_op_count;

    logic             w_push;
    logic             w_pop;
    logic [5:0]       w_flags_in;
    logic [2:0]       w_status_in;

    // Flow control comes from registered occupancy only, so in_ready has no path from out_ready.
    assign in_ready    = (r_count != 2'd2);
    assign out_valid   = (r_count != 2'd0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;

    assign w_status_in = {in_invalid_op, in_borrow, in_overflow};
    assign w_flags_in  = {w_status_in, in_c_out, in_y[WIDTH-1], (in_y == '0)};

    // Outputs are masked while empty so the unreset storage never reaches the consumer.
    assign out_y         = out_valid ? r_y_mem[r_head]   : '0;
    assign out_flags     = out_valid ? r_flg_mem[r_head] : '0;
    assign carry_flag    = r_carry;
    assign sticky_status = r_sticky;
    assign op_count      = r_op_count;

    // NOTE: the data array has no reset; only control state does, and out_* are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_y_mem[r_tail]   <= in_y;
            r_flg_mem[r_tail] <= w_flags_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_sticky   <= 3'b000;
            r_op_count <= '0;
        end else begin
            if (w_push) begin
                case (in_op)
                    OP_ADD, OP_ADC: r_carry <= in_c_out;
                    OP_SUB:         r_carry <= in_borrow;
                    default:        r_carry <= r_carry;
                endcase
                if (r_op_count != '1) r_op_count <= r_op_count + 1'b1;
            end
            // Clear takes effect before the OR, so a same-cycle push survives the clear.
            if (sticky_clr) r_sticky <= w_push ? w_status_in : 3'b000;
            else if (w_push) r_sticky <= r_sticky | w_status_in;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed-vector bench for alu_wb_stage; CNT_W=2 so counter saturation is reachable quickly.
module tb_alu_wb_stage;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_y;
    logic             in_c_out;
    logic             in_overflow;
    logic             in_borrow;
    logic             in_invalid_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [5:0]       out_flags;
    logic             carry_flag;
    logic [2:0]       sticky_status;
    logic             sticky_clr;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    alu_wb_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_y          (in_y),
        .in_c_out      (in_c_out),
        .in_overflow   (in_overflow),
        .in_borrow     (in_borrow),
        .in_invalid_op (in_invalid_op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .out_flags     (out_flags),
        .carry_flag    (carry_flag),
        .sticky_status (sticky_status),
        .sticky_clr    (sticky_clr),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] y,
                         input logic c, input logic ov, input logic bor, input logic inv);
        in_valid      = v;
        in_op         = op;
        in_y          = y;
        in_c_out      = c;
        in_overflow   = ov;
        in_borrow     = bor;
        in_invalid_op = inv;
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y",     32'(out_y), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_carry",     32'(carry_flag), 32'd0);
        chk("rst_sticky",    32'(sticky_status), 32'd0);
        chk("rst_op_count",  32'(op_count), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        // Single op: ADD y=5 with carry out.
        out_ready = 1'b1;
        drive(1, 4'd1, 8'h05, 1, 0, 0, 0);
        tick();
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        chk("single_valid",  32'(out_valid), 32'd1);
        chk("single_y",      32'(out_y), 32'h05);
        chk("single_flags",  32'(out_flags), 32'b000100);
        chk("single_carry",  32'(carry_flag), 32'd1);
        chk("single_count",  32'(op_count), 32'd1);
        tick();
        chk("single_drain",  32'(out_valid), 32'd0);

        // Backpressure: three results with consumer stalled.
        out_ready = 1'b0;
        drive(1, 4'd0, 8'h01, 0, 0, 0, 0);
        tick();
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        drive(1, 4'd0, 8'h02, 0, 0, 0, 0);
        tick();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_count_sat3", 32'(op_count), 32'd3);
        drive(1, 4'd0, 8'h03, 0, 0, 0, 0);
        tick();
        chk("bp_held_ready", 32'(in_ready), 32'd0);
        chk("bp_head_y1",    32'(out_y), 32'h01);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        chk("bp_head_y2",    32'(out_y), 32'h02);
        tick();
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        chk("bp_head_y3",    32'(out_y), 32'h03);
        chk("bp_count_saturated", 32'(op_count), 32'd3);
        chk("bp_carry_hold", 32'(carry_flag), 32'd1);
        tick();
        chk("bp_drained",    32'(out_valid), 32'd0);

        // Streaming: one in, one out per cycle with 1-cycle latency.
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'd0, 8'(8'h10 + i), 0, 0, 0, 0);
            tick();
            chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream_y_%0d", i),     32'(out_y), 32'(8'h10 + i));
            chk($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
        end
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Derived flags: negative then zero; carry untouched by ops 13 and 6.
        drive(1, 4'd13, 8'h80, 0, 0, 0, 0);
        tick();
        chk("flag_neg",        32'(out_flags), 32'b000010);
        chk("flag_neg_carry",  32'(carry_flag), 32'd1);
        drive(1, 4'd6, 8'h00, 0, 0, 0, 0);
        tick();
        chk("flag_zero",       32'(out_flags), 32'b000001);
        chk("flag_zero_carry", 32'(carry_flag), 32'd1);

        // ADC without carry out clears carry_flag.
        drive(1, 4'd2, 8'h07, 0, 0, 0, 0);
        tick();
        chk("adc_carry_clear", 32'(carry_flag), 32'd0);

        // SUB 2-5 borrows: result FD, carry_flag follows borrow.
        drive(1, 4'd3, 8'hFD, 0, 0, 1, 0);
        tick();
        chk("sub_flags",  32'(out_flags), 32'b010010);
        chk("sub_sticky", 32'(sticky_status), 32'b010);
        chk("sub_carry",  32'(carry_flag), 32'd1);

        // Clear together with an invalid-op push keeps only the pushed bits.
        sticky_clr = 1'b1;
        drive(1, 4'd15, 8'h00, 0, 0, 0, 1);
        tick();
        chk("clr_push_sticky", 32'(sticky_status), 32'b100);
        chk("clr_push_flags",  32'(out_flags), 32'b100001);
        chk("clr_push_carry",  32'(carry_flag), 32'd1);
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        tick();
        chk("clr_only_sticky", 32'(sticky_status), 32'b000);
        sticky_clr = 1'b0;

        // Asynchronous reset with the buffer full and the counter saturated.
        out_ready = 1'b0;
        drive(1, 4'd1, 8'h11, 1, 0, 0, 1);
        tick();
        drive(1, 4'd1, 8'h22, 1, 0, 0, 1);
        tick();
        drive(0, 4'd0, 8'h00, 0, 0, 0, 0);
        chk("pre_rst_full",   32'(in_ready), 32'd0);
        chk("pre_rst_count",  32'(op_count), 32'd3);
        chk("pre_rst_sticky", 32'(sticky_status), 32'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  32'(out_valid), 32'd0);
        chk("async_rst_count",  32'(op_count), 32'd0);
        chk("async_rst_carry",  32'(carry_flag), 32'd0);
        chk("async_rst_sticky", 32'(sticky_status), 32'd0);
        chk("async_rst_y",      32'(out_y), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
